// File: rtl/mod7_serial_tx.sv
// Serial transmitter: shifts a parallel word out MSB-first, then appends the
// word's residue mod 7 as a 3-bit MSB-first trailer.
module mod7_serial_tx #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             frame,
    output logic             trailer,
    output logic             done,
    output logic [2:0]       residue
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_TRAIL = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] shift_q,    shift_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [2:0]       r_q,        r_d;
    logic             data_out_q, data_out_d;
    logic             frame_q,    frame_d;
    logic             trailer_q,  trailer_d;
    logic             done_q,     done_d;
    logic [2:0]       residue_q,  residue_d;

    logic [3:0]       r_sum;
    logic [2:0]       r_step;

    // One step of the residue recurrence: (2*r + bit) mod 7, reduced before storage.
    always_comb begin
        r_sum  = {r_q, shift_q[WIDTH-1]};
        r_step = (r_sum >= 4'd7) ? 3'(r_sum - 4'd7) : r_sum[2:0];
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        data_out_d = data_out_q;
        frame_d    = frame_q;
        trailer_d  = trailer_q;
        done_d     = 1'b0;
        residue_d  = residue_q;

        case (state_q)
            S_IDLE: begin
                data_out_d = 1'b0;
                frame_d    = 1'b0;
                trailer_d  = 1'b0;
                if (in_valid) begin
                    state_d    = S_DATA;
                    shift_d    = data_in;
                    cnt_d      = '0;
                    r_d        = 3'd0;
                    data_out_d = data_in[WIDTH-1];
                    frame_d    = 1'b1;
                end
            end
            S_DATA: begin
                r_d        = r_step;
                shift_d    = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d      = cnt_q + CW'(1);
                data_out_d = shift_q[WIDTH-2];
                // Last payload bit: the first trailer bit comes from the just-finished residue.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = S_TRAIL;
                    cnt_d      = '0;
                    data_out_d = r_step[2];
                    trailer_d  = 1'b1;
                end
            end
            S_TRAIL: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(0)) begin
                    data_out_d = r_q[1];
                end else if (cnt_q == CW'(1)) begin
                    data_out_d = r_q[0];
                    done_d     = 1'b1;
                    residue_d  = r_q;
                end else begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    data_out_d = 1'b0;
                    frame_d    = 1'b0;
                    trailer_d  = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                cnt_d      = '0;
                data_out_d = 1'b0;
                frame_d    = 1'b0;
                trailer_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            r_q        <= 3'd0;
            data_out_q <= 1'b0;
            frame_q    <= 1'b0;
            trailer_q  <= 1'b0;
            done_q     <= 1'b0;
            residue_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            data_out_q <= data_out_d;
            frame_q    <= frame_d;
            trailer_q  <= trailer_d;
            done_q     <= done_d;
            residue_q  <= residue_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign data_out = data_out_q;
    assign frame    = frame_q;
    assign trailer  = trailer_q;
    assign done     = done_q;
    assign residue  = residue_q;

endmodule

// File: tb/tb_mod7_serial_tx.sv
// Bench for mod7_serial_tx: a frame-level model (bit list + word % 7) is checked
// against the DUT every cycle, plus directed frames with hand-computed trailers.
module tb_mod7_serial_tx;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic        data_out;
    logic        frame;
    logic        trailer;
    logic        done;
    logic [2:0]  residue;

    int vectors = 0;
    int miscompares = 0;

    mod7_serial_tx #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (data_out),
        .frame    (frame),
        .trailer  (trailer),
        .done     (done),
        .residue  (residue)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected output per cycle, built a whole frame at a time on accept.
    typedef struct packed {
        logic       d;
        logic       f;
        logic       t;
        logic       dn;
        logic [2:0] res;
    } cyc_t;

    cyc_t       q[$];
    cyc_t       cur;
    logic [2:0] exp_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur     = '0;
            exp_res = 3'd0;
        end else if (!cur.f && in_valid) begin
            logic [2:0] m;
            m = 3'(data_in % 16'd7);
            for (int i = 15; i >= 0; i--) q.push_back('{data_in[i], 1'b1, 1'b0, 1'b0, m});
            q.push_back('{m[2], 1'b1, 1'b1, 1'b0, m});
            q.push_back('{m[1], 1'b1, 1'b1, 1'b0, m});
            q.push_back('{m[0], 1'b1, 1'b1, 1'b1, m});
            cur = q.pop_front();
        end else if (q.size() > 0) begin
            cur = q.pop_front();
            if (cur.dn) exp_res = cur.res;
        end else begin
            cur = '0;
        end
    end

    always @(negedge clk) begin
        check("data_out", 32'(data_out), 32'(cur.d));
        check("frame",    32'(frame),    32'(cur.f));
        check("trailer",  32'(trailer),  32'(cur.t));
        check("done",     32'(done),     32'(cur.dn));
        check("residue",  32'(residue),  32'(exp_res));
        check("in_ready", 32'(in_ready), 32'(!cur.f));
    end

    // Waits for in_ready, presents a word, returns just after the accepting edge.
    task automatic accept(input logic [15:0] w, input logic hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        data_in  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Collects one frame right after its accept edge and pins it to literal values.
    task automatic run_frame(input logic [15:0] w, input logic [2:0] t, input string tag);
        logic [15:0] pay;
        logic [2:0]  tr;
        int          done_at;
        pay     = '0;
        tr      = '0;
        done_at = 0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k <= 16) pay = {pay[14:0], data_out};
            else         tr  = {tr[1:0], data_out};
            if (done && done_at == 0) done_at = k;
        end
        check({tag, "_payload"}, 32'(pay), 32'(w));
        check({tag, "_trailer"}, 32'(tr), 32'(t));
        check({tag, "_done_cycle"}, 32'(done_at), 32'd19);
        check({tag, "_residue"}, 32'(residue), 32'(t));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        #2;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_frame",    32'(frame),    32'd0);
        check("rst_residue",  32'(residue),  32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        accept(16'h1234, 1'b0); run_frame(16'h1234, 3'b101, "w1234");
        accept(16'hFFFF, 1'b0); run_frame(16'hFFFF, 3'b001, "wFFFF");
        accept(16'h8000, 1'b0); run_frame(16'h8000, 3'b001, "w8000");
        accept(16'h0007, 1'b0); run_frame(16'h0007, 3'b000, "w0007");
        accept(16'h0000, 1'b0); run_frame(16'h0000, 3'b000, "w0000");

        // Back-to-back with in_valid held: one idle gap between frames.
        accept(16'h0001, 1'b1);
        data_in = 16'h000A;
        run_frame(16'h0001, 3'b001, "b2b_first");
        @(negedge clk);
        check("b2b_gap_frame", 32'(frame), 32'd0);
        check("b2b_gap_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        run_frame(16'h000A, 3'b011, "b2b_second");

        // New word and in_valid pulse while busy must not disturb the frame.
        accept(16'h1234, 1'b0);
        fork
            run_frame(16'h1234, 3'b101, "busy");
            begin
                repeat (5) @(posedge clk);
                #1;
                data_in  = 16'hBEEF;
                in_valid = 1'b1;
                @(negedge clk);
                check("busy_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        join

        // Reset in the middle of the payload.
        accept(16'h5555, 1'b0);
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_frame",    32'(frame),    32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_trailer",  32'(trailer),  32'd0);
        check("midrst_done",     32'(done),     32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        accept(16'h1234, 1'b0); run_frame(16'h1234, 3'b101, "post_rst");

        // Random words, one third of them in 7*k+m form.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] w;
            if (i % 3 == 0) w = 16'(7 * $urandom_range(0, 9361) + $urandom_range(0, 6));
            else            w = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            accept(w, 1'b0);
            run_frame(w, 3'(w % 16'd7), "rand");
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
